ballot_controller: RTL and testbench

Sequences the four-candidate voting datapath one voter at a time. It sits between the per-candidate debounced `valid_vote` pulses and the vote logger. It accepts exactly one vote per ballot issued by the presiding officer, and rejects ambiguous or late presses. It also keeps session statistics and drives the confirm indication.

---
 rtl/ballot_controller.sv | 80 ++++++++
 tb/tb_ballot_controller.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ballot_controller.sv
// ballot_controller: one-vote-per-ballot sequencer with timeout, spoil detection and session statistics
module ballot_controller #(
    parameter int N_CAND      = 4,
    parameter int TIMEOUT     = 1000,
    parameter int CONFIRM_CYC = 10,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              poll_open,
    input  logic              issue_ballot,
    input  logic [N_CAND-1:0] valid_vote,
    output logic [N_CAND-1:0] vote_strobe,
    output logic              ballot_armed,
    output logic              confirm,
    output logic [CNT_W-1:0]  total_cnt,
    output logic [CNT_W-1:0]  spoiled_cnt,
    output logic [CNT_W-1:0]  timeout_cnt
);
    localparam int TW = $clog2(TIMEOUT);
    localparam int CW = $clog2(CONFIRM_CYC + 1);
    typedef enum logic [1:0] {CLOSED, IDLE, ARMED, CONFIRM} state_t;
    state_t        state;
    logic [TW-1:0] tmr;
    logic [CW-1:0] ccnt;
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return c + CNT_W'(c != '1);
    endfunction
    always_ff @(posedge clk) begin
        vote_strobe <= '0;
        if (rst) begin
            state        <= CLOSED;
            tmr          <= '0;
            ccnt         <= '0;
            ballot_armed <= 1'b0;
            confirm      <= 1'b0;
            total_cnt    <= '0;
            spoiled_cnt  <= '0;
            timeout_cnt  <= '0;
        end else if (!poll_open) begin
            state        <= CLOSED;
            ballot_armed <= 1'b0;
            confirm      <= 1'b0;
        end else begin
            case (state)
                CLOSED: state <= IDLE;
                IDLE: if (issue_ballot) begin
                    state        <= ARMED;
                    ballot_armed <= 1'b1;
                    tmr          <= TW'(TIMEOUT - 1);
                end
                ARMED: if ($onehot(valid_vote)) begin
                    vote_strobe  <= valid_vote;
                    total_cnt    <= sat_inc(total_cnt);
                    state        <= CONFIRM;
                    ballot_armed <= 1'b0;
                    confirm      <= 1'b1;
                    ccnt         <= CW'(CONFIRM_CYC - 1);
                end else if (valid_vote != '0) begin
                    spoiled_cnt  <= sat_inc(spoiled_cnt);
                    state        <= IDLE;
                    ballot_armed <= 1'b0;
                end else if (tmr == '0) begin
                    timeout_cnt  <= sat_inc(timeout_cnt);
                    state        <= IDLE;
                    ballot_armed <= 1'b0;
                end else begin
                    tmr <= tmr - TW'(1);
                end
                CONFIRM: if (ccnt == '0) begin
                    state   <= IDLE;
                    confirm <= 1'b0;
                end else begin
                    ccnt <= ccnt - CW'(1);
                end
                default: state <= CLOSED;
            endcase
        end
    end
endmodule

// File: tb/tb_ballot_controller.sv
// tb_ballot_controller: directed checks of ballot sequencing, timeout, spoiling, poll close and saturation
module tb_ballot_controller;
    logic       clk = 1'b0;
    logic       rst, poll_open, issue_ballot;
    logic [3:0] valid_vote, vote_strobe;
    logic       ballot_armed, confirm;
    logic [7:0] total_cnt, spoiled_cnt, timeout_cnt;
    int         errors = 0;
    int         checks = 0;
    int         n;

    ballot_controller dut (
        .clk(clk), .rst(rst), .poll_open(poll_open), .issue_ballot(issue_ballot),
        .valid_vote(valid_vote), .vote_strobe(vote_strobe), .ballot_armed(ballot_armed),
        .confirm(confirm), .total_cnt(total_cnt), .spoiled_cnt(spoiled_cnt), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    initial begin
        rst = 1'b1; poll_open = 1'b0; issue_ballot = 1'b0; valid_vote = 4'b0000;
        tick(); tick();
        chk("rst_strobe", 32'(vote_strobe), 0);
        chk("rst_armed", 32'(ballot_armed), 0);
        chk("rst_confirm", 32'(confirm), 0);
        chk("rst_total", 32'(total_cnt), 0);
        chk("rst_spoiled", 32'(spoiled_cnt), 0);
        chk("rst_timeout", 32'(timeout_cnt), 0);
        // test 1: accepted vote
        rst = 1'b0; poll_open = 1'b1; tick();
        issue_ballot = 1'b1; tick(); issue_ballot = 1'b0;
        chk("t1_armed", 32'(ballot_armed), 1);
        ticks(4);
        valid_vote = 4'b0100; tick(); valid_vote = 4'b0000;
        chk("t1_strobe", 32'(vote_strobe), 32'h4);
        chk("t1_total", 32'(total_cnt), 1);
        chk("t1_armed_fall", 32'(ballot_armed), 0);
        chk("t1_confirm_rise", 32'(confirm), 1);
        n = 1;
        tick();
        chk("t1_strobe_once", 32'(vote_strobe), 0);
        if (confirm) n++;
        while (confirm && n < 50) begin
            tick();
            if (confirm) n++;
        end
        chk("t1_confirm_len", 32'(n), 10);
        // test 2: spoiled ballot
        issue_ballot = 1'b1; tick(); issue_ballot = 1'b0;
        valid_vote = 4'b0011; tick(); valid_vote = 4'b0000;
        chk("t2_strobe", 32'(vote_strobe), 0);
        chk("t2_spoiled", 32'(spoiled_cnt), 1);
        chk("t2_armed", 32'(ballot_armed), 0);
        chk("t2_total", 32'(total_cnt), 1);
        // test 3: timeout window and late/last-cycle press
        issue_ballot = 1'b1; tick(); issue_ballot = 1'b0;
        n = 0;
        while (ballot_armed && n < 2000) begin
            n++;
            tick();
        end
        chk("t3_armed_len", 32'(n), 1000);
        chk("t3_timeout", 32'(timeout_cnt), 1);
        valid_vote = 4'b0001; tick(); valid_vote = 4'b0000;
        chk("t3_late_strobe", 32'(vote_strobe), 0);
        chk("t3_late_total", 32'(total_cnt), 1);
        issue_ballot = 1'b1; tick(); issue_ballot = 1'b0;
        ticks(999);
        chk("t3_still_armed", 32'(ballot_armed), 1);
        valid_vote = 4'b0001; tick(); valid_vote = 4'b0000;
        chk("t3_edge_strobe", 32'(vote_strobe), 32'h1);
        chk("t3_edge_total", 32'(total_cnt), 2);
        chk("t3_edge_timeout", 32'(timeout_cnt), 1);
        ticks(10);
        chk("t3_confirm_done", 32'(confirm), 0);
        // test 4: stray presses in IDLE, CLOSED and CONFIRM
        valid_vote = 4'b0001; tick(); valid_vote = 4'b0000;
        chk("t4_idle_strobe", 32'(vote_strobe), 0);
        poll_open = 1'b0; tick();
        valid_vote = 4'b0001; tick(); valid_vote = 4'b0000;
        chk("t4_closed_strobe", 32'(vote_strobe), 0);
        chk("t4_closed_total", 32'(total_cnt), 2);
        poll_open = 1'b1; tick();
        issue_ballot = 1'b1; valid_vote = 4'b0001; tick(); issue_ballot = 1'b0; valid_vote = 4'b0000;
        chk("t4_issue_press_strobe", 32'(vote_strobe), 0);
        chk("t4_issue_press_armed", 32'(ballot_armed), 1);
        valid_vote = 4'b0001; tick(); valid_vote = 4'b0000;
        chk("t4_armed_strobe", 32'(vote_strobe), 32'h1);
        valid_vote = 4'b0001; tick(); valid_vote = 4'b0000;
        chk("t4_confirm_strobe", 32'(vote_strobe), 0);
        chk("t4_total", 32'(total_cnt), 3);
        ticks(10);
        chk("t4_spoiled", 32'(spoiled_cnt), 1);
        chk("t4_timeout", 32'(timeout_cnt), 1);
        // test 5: poll close mid-ARMED and mid-CONFIRM
        issue_ballot = 1'b1; tick(); issue_ballot = 1'b0;
        ticks(3);
        poll_open = 1'b0; tick();
        chk("t5_armed_drop", 32'(ballot_armed), 0);
        chk("t5_total_keep", 32'(total_cnt), 3);
        chk("t5_timeout_keep", 32'(timeout_cnt), 1);
        poll_open = 1'b1; tick();
        issue_ballot = 1'b1; tick(); issue_ballot = 1'b0;
        valid_vote = 4'b0010; tick(); valid_vote = 4'b0000;
        chk("t5_vote", 32'(total_cnt), 4);
        ticks(2);
        poll_open = 1'b0; tick();
        chk("t5_confirm_drop", 32'(confirm), 0);
        poll_open = 1'b1; tick();
        chk("t5_total_retained", 32'(total_cnt), 4);
        // test 6: saturation then reset abandoning an armed ballot
        for (int v = 0; v < 256; v++) begin
            issue_ballot = 1'b1; tick(); issue_ballot = 1'b0;
            valid_vote = 4'b1000; tick(); valid_vote = 4'b0000;
            ticks(10);
        end
        chk("t6_saturate", 32'(total_cnt), 255);
        chk("t6_spoiled", 32'(spoiled_cnt), 1);
        issue_ballot = 1'b1; tick(); issue_ballot = 1'b0;
        rst = 1'b1; valid_vote = 4'b1000; tick(); valid_vote = 4'b0000;
        chk("t6_rst_strobe", 32'(vote_strobe), 0);
        chk("t6_rst_armed", 32'(ballot_armed), 0);
        chk("t6_rst_confirm", 32'(confirm), 0);
        chk("t6_rst_total", 32'(total_cnt), 0);
        chk("t6_rst_spoiled", 32'(spoiled_cnt), 0);
        chk("t6_rst_timeout", 32'(timeout_cnt), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
